// File: rtl/network_pkg.sv
// rtl/network_pkg.sv - shared types and helpers for the CNN network sequencer
package network_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } seq_state_t;

  // Index width able to hold n-1; never narrower than one bit.
  function automatic int logb2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - modulo-MAX counter with sync clear and last-value flag
module wrap_counter #(
  parameter int MAX   = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  assign last = (cnt == WIDTH'(MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/network_sequencer.sv
// rtl/network_sequencer.sv - steps a batch of images through the layer engines one layer at a time
module network_sequencer
  import network_pkg::*;
#(
  parameter  int IMAGE_NUM   = 5,
  parameter  int LAYER_NUM   = 3,
  localparam int IMAGE_WIDTH = logb2(IMAGE_NUM),
  localparam int LAYER_WIDTH = logb2(LAYER_NUM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [LAYER_NUM-1:0]   layer_calc_fin,
  output logic [LAYER_NUM-1:0]   layer_en,
  output logic [IMAGE_WIDTH-1:0] image_idx,
  output logic [LAYER_WIDTH-1:0] layer_idx,
  output logic                   busy,
  output logic                   image_done,
  output logic                   batch_done
);

  seq_state_t           state;
  logic                 fin_hit;
  logic                 layer_last;
  logic                 image_last;
  logic [LAYER_NUM-1:0] en_decode;

  // layer_en is one-hot on layer_idx in RUN and zero elsewhere, so masking
  // with it honours only the active layer's fin and nothing in GAP/IDLE.
  assign fin_hit   = (state == RUN) && (|(layer_calc_fin & layer_en)) && !abort;
  assign en_decode = LAYER_NUM'(1) << layer_idx;

  wrap_counter #(.MAX(LAYER_NUM), .WIDTH(LAYER_WIDTH)) u_layer_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .inc   (fin_hit),
    .cnt   (layer_idx),
    .last  (layer_last)
  );

  wrap_counter #(.MAX(IMAGE_NUM), .WIDTH(IMAGE_WIDTH)) u_image_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (abort),
    .inc   (fin_hit && layer_last),
    .cnt   (image_idx),
    .last  (image_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      layer_en   <= '0;
      busy       <= 1'b0;
      image_done <= 1'b0;
      batch_done <= 1'b0;
    end else begin
      image_done <= 1'b0;
      batch_done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        layer_en <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= RUN;
              layer_en <= en_decode;
              busy     <= 1'b1;
            end
          end
          RUN: begin
            if (fin_hit) begin
              layer_en <= '0;
              state    <= GAP;
              if (layer_last) begin
                image_done <= 1'b1;
                if (image_last) begin
                  batch_done <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
                end
              end
            end
          end
          GAP: begin
            state    <= RUN;
            layer_en <= en_decode;
          end
          default: begin
            state    <= IDLE;
            layer_en <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  a_en_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(layer_en));
  a_en_in_run: assert property (@(posedge clk) disable iff (!rst_n) (layer_en != '0) |-> (state == RUN));
  a_batch_img: assert property (@(posedge clk) disable iff (!rst_n) batch_done |-> image_done);

endmodule

// File: tb/tb_network_sequencer.sv
// tb/tb_network_sequencer.sv - scoreboard bench for network_sequencer
module tb_network_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] auto_fin = '0;
  logic [2:0] inj_fin = '0;
  logic [2:0] layer_calc_fin;
  logic [2:0] layer_en;
  logic [2:0] image_idx;
  logic [1:0] layer_idx;
  logic       busy, image_done, batch_done;

  logic       start11 = 1'b0, fin11 = 1'b0, abort11 = 1'b0;
  logic [0:0] en11, img11, lay11;
  logic       busy11, idone11, bdone11;

  logic       start84 = 1'b0, abort84 = 1'b0;
  logic [3:0] fin84 = '0;
  logic [3:0] en84;
  logic [2:0] img84;
  logic [1:0] lay84;
  logic       busy84, idone84, bdone84;

  int n_checks = 0;
  int n_fail = 0;
  bit auto_on = 1'b0;

  assign layer_calc_fin = auto_fin | inj_fin;

  always #5 clk = ~clk;

  network_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_calc_fin(layer_calc_fin), .layer_en(layer_en),
    .image_idx(image_idx), .layer_idx(layer_idx), .busy(busy),
    .image_done(image_done), .batch_done(batch_done)
  );

  network_sequencer #(.IMAGE_NUM(1), .LAYER_NUM(1)) dut11 (
    .clk(clk), .rst_n(rst_n), .start(start11), .abort(abort11),
    .layer_calc_fin(fin11), .layer_en(en11), .image_idx(img11),
    .layer_idx(lay11), .busy(busy11), .image_done(idone11), .batch_done(bdone11)
  );

  network_sequencer #(.IMAGE_NUM(8), .LAYER_NUM(4)) dut84 (
    .clk(clk), .rst_n(rst_n), .start(start84), .abort(abort84),
    .layer_calc_fin(fin84), .layer_en(en84), .image_idx(img84),
    .layer_idx(lay84), .busy(busy84), .image_done(idone84), .batch_done(bdone84)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct { int img; int lay; } en_t;
  typedef struct { int nxt; bit batch; } done_t;
  en_t   en_q[$];
  done_t done_q[$];

  task automatic push_windows(input int img_from, input int lay_from, input int img_to, input int lay_to);
    int i, l;
    i = img_from;
    l = lay_from;
    while (i < img_to || (i == img_to && l <= lay_to)) begin
      en_q.push_back('{img: i, lay: l});
      if (l == 2) begin
        done_q.push_back('{nxt: (i == 4) ? 0 : i + 1, batch: (i == 4)});
        l = 0;
        i++;
      end else begin
        l++;
      end
    end
  endtask

  // Engine model: fin returned on the 4th cycle of each enable window.
  int age = 0;
  always @(negedge clk) begin
    if (layer_en != '0) age++;
    else age = 0;
    auto_fin = (auto_on && age == 4) ? layer_en : 3'b000;
  end

  logic [2:0] prev_en = '0;
  logic       prev_busy = 1'b0;
  int         gap_len = 0;
  always @(negedge clk) begin
    en_t   e;
    done_t d;
    if (rst_n) begin
      if (layer_en != '0 && prev_en == '0) begin
        check_eq("enable_expected", en_q.size() > 0, 1);
        if (en_q.size() > 0) begin
          e = en_q.pop_front();
          check_eq("win_layer_en", layer_en, 1 << e.lay);
          check_eq("win_image_idx", image_idx, e.img);
          check_eq("win_layer_idx", layer_idx, e.lay);
          if (prev_busy) check_eq("gap_len", gap_len, 1);
        end
      end
      if (image_done) begin
        check_eq("image_done_expected", done_q.size() > 0, 1);
        if (done_q.size() > 0) begin
          d = done_q.pop_front();
          check_eq("batch_done_pulse", batch_done, d.batch);
          check_eq("done_next_image", image_idx, d.nxt);
          check_eq("done_busy", busy, !d.batch);
        end
      end else if (batch_done) begin
        check_eq("batch_without_image", image_done, 1);
      end
    end
    gap_len   = (layer_en == '0) ? gap_len + 1 : 0;
    prev_en   = layer_en;
    prev_busy = busy;
  end

  // 8x4 instance: fin on the 2nd cycle of each window, model walks layer then image.
  int age84 = 0, m_img = 0, m_lay = 0, win84 = 0, idone_cnt = 0, bdone_cnt = 0;
  logic [3:0] prev84 = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (en84 != '0 && prev84 == '0) begin
        check_eq("p84_layer_en", en84, 1 << m_lay);
        check_eq("p84_image_idx", img84, m_img);
        check_eq("p84_layer_idx", lay84, m_lay);
        win84++;
        m_lay++;
        if (m_lay == 4) begin
          m_lay = 0;
          m_img = (m_img + 1) % 8;
        end
      end
      if (idone84) idone_cnt++;
      if (bdone84) bdone_cnt++;
    end
    prev84 = en84;
    if (en84 != '0) age84++;
    else age84 = 0;
    fin84 = (age84 == 2) ? en84 : 4'b0000;
  end

  task automatic wait_batch_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (batch_done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq(tag, seen, 1);
  endtask

  initial begin
    bit found;
    #2;
    check_eq("rst_layer_en", layer_en, 0);
    check_eq("rst_image_idx", image_idx, 0);
    check_eq("rst_layer_idx", layer_idx, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_image_done", image_done, 0);
    check_eq("rst_batch_done", batch_done, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full batch from a one-cycle start pulse.
    auto_on = 1'b1;
    push_windows(0, 0, 4, 2);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq("start_busy", busy, 1);
    wait_batch_done("batch_a_done");
    @(negedge clk);
    check_eq("a_idle_busy", busy, 0);
    check_eq("a_idle_en", layer_en, 0);
    check_eq("a_windows_left", en_q.size(), 0);
    check_eq("a_dones_left", done_q.size(), 0);

    // start held through the batch: no restart, ignored on completion, new batch one cycle later.
    push_windows(0, 0, 4, 2);
    start = 1'b1;
    wait_batch_done("batch_b_done");
    check_eq("b_start_at_finish_ignored", busy, 0);
    push_windows(0, 0, 4, 2);
    @(posedge clk);
    #1;
    check_eq("c_restart_busy", busy, 1);
    check_eq("c_restart_en", layer_en, 3'b001);
    start = 1'b0;
    wait_batch_done("batch_c_done");
    @(negedge clk);
    check_eq("c_windows_left", en_q.size(), 0);

    // Non-active fin and fin during GAP are ignored.
    auto_on = 1'b0;
    push_windows(0, 0, 0, 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    inj_fin = 3'b100;
    @(negedge clk) inj_fin = 3'b000;
    check_eq("wrong_bit_en", layer_en, 3'b001);
    check_eq("wrong_bit_idx", layer_idx, 0);
    inj_fin = 3'b001;
    @(negedge clk) inj_fin = 3'b010;
    check_eq("gap_en_zero", layer_en, 0);
    check_eq("gap_idx", layer_idx, 1);
    @(negedge clk) inj_fin = 3'b000;
    check_eq("gap_fin_ignored_idx", layer_idx, 1);
    check_eq("gap_fin_ignored_en", layer_en, 3'b010);

    // Abort coincident with fin at image 2 layer 1.
    en_q.push_back('{img: 0, lay: 2});
    done_q.push_back('{nxt: 1, batch: 1'b0});
    push_windows(1, 0, 2, 1);
    auto_on = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (image_idx == 3'd2 && layer_en == 3'b010) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_img2_l1", found, 1);
    auto_on = 1'b0;
    @(negedge clk);
    inj_fin = 3'b010;
    abort = 1'b1;
    @(negedge clk);
    inj_fin = 3'b000;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_en", layer_en, 0);
    check_eq("abort_image_idx", image_idx, 0);
    check_eq("abort_layer_idx", layer_idx, 0);
    check_eq("abort_image_done", image_done, 0);
    check_eq("abort_windows_left", en_q.size(), 0);
    check_eq("abort_dones_left", done_q.size(), 0);

    // Asynchronous reset mid-RUN.
    auto_on = 1'b1;
    push_windows(0, 0, 0, 1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (layer_en == 3'b010) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_l1", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_en", layer_en, 0);
    check_eq("arst_image_idx", image_idx, 0);
    check_eq("arst_layer_idx", layer_idx, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_image_done", image_done, 0);
    check_eq("arst_batch_done", batch_done, 0);
    en_q.delete();
    done_q.delete();
    auto_on = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Parameter sweep instances.
    @(negedge clk) start84 = 1'b1;
    @(negedge clk) start84 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk) start11 = 1'b1;
      @(negedge clk) start11 = 1'b0;
      check_eq("p11_en", en11, 1);
      fin11 = 1'b1;
      @(negedge clk) fin11 = 1'b0;
      check_eq("p11_image_done", idone11, 1);
      check_eq("p11_batch_done", bdone11, 1);
      check_eq("p11_busy", busy11, 0);
      check_eq("p11_en_off", en11, 0);
    end
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bdone84) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("p84_batch_seen", found, 1);
    @(negedge clk);
    check_eq("p84_windows", win84, 32);
    check_eq("p84_image_dones", idone_cnt, 8);
    check_eq("p84_batch_dones", bdone_cnt, 1);
    check_eq("p84_busy", busy84, 0);
    check_eq("p84_image_wrap", img84, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
